// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, latency defaults.
// Optional multiply-accumulate ops are enabled with the MDU_MADD_EN macro.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;
  localparam int MDU_CNT_W           = 16;

  function automatic logic is_div_op(logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Ops that occupy the unit for a multi-cycle latency.
  function automatic logic is_long_op(logic [3:0] op);
    logic r;
    r = (op == MDU_MULT) || (op == MDU_MULTU) || is_div_op(op);
`ifdef MDU_MADD_EN
    r = r || (op == MDU_MADD) || (op == MDU_MADDU);
`endif
    return r;
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface mdu_unit_if;
  logic        start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, MDUOp, A, B, input busy, HI, LO);
  modport slave  (input start, MDUOp, A, B, output busy, HI, LO);
endinterface

// File: rtl/mdu_compute.sv
// Combinational result generation for the latched op; HI/LO pass through unchanged
// when nothing is produced. madd/maddu exist only with MDU_MADD_EN defined.
module mdu_compute
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] hi_next,
  output logic [31:0] lo_next,
  output logic        div_zero
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        a_mag, b_mag, div_a, div_b, uq, ur;
  logic [31:0]        q_s, r_s;
  logic               sgn;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // One unsigned divider serves both flavours; signed division works on magnitudes,
  // which makes 0x80000000 / -1 wrap to 0x80000000 without special casing.
  assign sgn   = (op == MDU_DIV);
  assign a_mag = a[31] ? (~a + 32'd1) : a;
  assign b_mag = b[31] ? (~b + 32'd1) : b;
  assign div_a = sgn ? a_mag : a;
  assign div_b = sgn ? b_mag : b;
  assign uq    = (div_b == 32'd0) ? 32'd0 : div_a / div_b;
  assign ur    = (div_b == 32'd0) ? 32'd0 : div_a % div_b;
  assign q_s   = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
  assign r_s   = a[31] ? (~ur + 32'd1) : ur;

  always_comb begin
    hi_next  = hi;
    lo_next  = lo;
    div_zero = 1'b0;
    case (op)
      MDU_MULT:  {hi_next, lo_next} = prod_s;
      MDU_MULTU: {hi_next, lo_next} = prod_u;
      MDU_DIV, MDU_DIVU: begin
        if (b == 32'd0) begin
          div_zero = 1'b1;
        end else if (sgn) begin
          hi_next = r_s;
          lo_next = q_s;
        end else begin
          hi_next = ur;
          lo_next = uq;
        end
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  {hi_next, lo_next} = {hi, lo} + prod_s;
      MDU_MADDU: {hi_next, lo_next} = {hi, lo} + prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit: FSM, latency counter, operand latches and HI/LO.
// MDU_MADD_EN adds madd/maddu (accumulate into HI/LO at commit time).
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  mdu_unit_if.slave  bus
);

  mdu_state_e           state_reg, state_next;
  logic [MDU_CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]           op_reg, op_next;
  logic [31:0]          a_reg, a_next, b_reg, b_next;
  logic [31:0]          hi_reg, hi_next, lo_reg, lo_next;
  logic [31:0]          res_hi, res_lo;
  logic                 res_div_zero;

  mdu_compute u_compute (
    .op       (op_reg),
    .a        (a_reg),
    .b        (b_reg),
    .hi       (hi_reg),
    .lo       (lo_reg),
    .hi_next  (res_hi),
    .lo_next  (res_lo),
    .div_zero (res_div_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= MDU_NONE;
      a_reg     <= '0;
      b_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (is_long_op(bus.MDUOp)) begin
            state_next = BUSY;
            op_next    = bus.MDUOp;
            a_next     = bus.A;
            b_next     = bus.B;
            cnt_next   = is_div_op(bus.MDUOp) ? MDU_CNT_W'(DIV_CYCLES - 1)
                                              : MDU_CNT_W'(MULT_CYCLES - 1);
          end else if (bus.MDUOp == MDU_MTHI) begin
            hi_next = bus.A;
          end else if (bus.MDUOp == MDU_MTLO) begin
            lo_next = bus.A;
          end
        end
      end
      BUSY: begin
        // start is deliberately not looked at here: no queueing, no relatch.
        if (cnt_reg == '0) begin
          state_next = IDLE;
          if (!res_div_zero) begin
            hi_next = res_hi;
            lo_next = res_lo;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state_reg == BUSY);
  assign bus.HI   = hi_reg;
  assign bus.LO   = lo_reg;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases with literal results plus
// randomized traffic compared cycle by cycle against an arithmetic model.
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  mdu_unit_if bus ();

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          left = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [3:0]  p_op = 0;
  logic [31:0] p_a = 0, p_b = 0;

  function automatic logic [63:0] sprod(logic [31:0] x, logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  function automatic logic [63:0] uprod(logic [31:0] x, logic [31:0] y);
    longint unsigned ux, uy;
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  task automatic model_commit();
    int sa, sb, q, r;
    case (p_op)
      4'd1: {m_hi, m_lo} = sprod(p_a, p_b);
      4'd2: {m_hi, m_lo} = uprod(p_a, p_b);
      4'd3: if (p_b != 0) begin
        sa = p_a; sb = p_b;
        if (sa == 32'h8000_0000 && sb == -1) begin q = sa; r = 0; end
        else begin q = sa / sb; r = sa % sb; end
        m_lo = q; m_hi = r;
      end
      4'd4: if (p_b != 0) begin m_lo = p_a / p_b; m_hi = p_a % p_b; end
`ifdef MDU_MADD_EN
      4'd7: {m_hi, m_lo} = {m_hi, m_lo} + sprod(p_a, p_b);
      4'd8: {m_hi, m_lo} = {m_hi, m_lo} + uprod(p_a, p_b);
`endif
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_hi = 0; m_lo = 0; left = 0;
    end else if (left > 0) begin
      left = left - 1;
      if (left == 0) model_commit();
    end else if (bus.start) begin
      case (bus.MDUOp)
        4'd1, 4'd2
`ifdef MDU_MADD_EN
        , 4'd7, 4'd8
`endif
        : begin left = MC; p_op = bus.MDUOp; p_a = bus.A; p_b = bus.B; end
        4'd3, 4'd4: begin left = DC; p_op = bus.MDUOp; p_a = bus.A; p_b = bus.B; end
        4'd5: m_hi = bus.A;
        4'd6: m_lo = bus.A;
        default: ;
      endcase
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", {31'd0, bus.busy}, {31'd0, (left > 0)});
      check("cyc_hi", bus.HI, m_hi);
      check("cyc_lo", bus.LO, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    @(negedge clk);
    bus.start = 1'b1; bus.MDUOp = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    cyc = 0;
    while (bus.busy && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    $display("op=%0d a=%08h b=%08h busy_cycles=%0d HI=%08h LO=%08h", op, a, b, cyc, bus.HI, bus.LO);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    bus.start = 1'b0; bus.MDUOp = 4'd0; bus.A = 0; bus.B = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_hi", bus.HI, 32'd0);
    check("reset_lo", bus.LO, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // mult with negative operand
    run_op(4'd1, 32'hFFFF_FFFD, 32'd5, cyc);
    check("mult_busy_cycles", cyc, MC);
    check("mult_hi", bus.HI, 32'hFFFF_FFFF);
    check("mult_lo", bus.LO, 32'hFFFF_FFF1);
    check("model_mult_lo", m_lo, 32'hFFFF_FFF1);

    run_op(4'd4, 32'd7, 32'd2, cyc);
    check("divu_busy_cycles", cyc, DC);
    check("divu_lo", bus.LO, 32'd3);
    check("divu_hi", bus.HI, 32'd1);

    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, cyc);
    check("div_lo", bus.LO, 32'hFFFF_FFFD);
    check("div_hi", bus.HI, 32'hFFFF_FFFF);
    check("model_div_hi", m_hi, 32'hFFFF_FFFF);

    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check("div_ovf_lo", bus.LO, 32'h8000_0000);
    check("div_ovf_hi", bus.HI, 32'h0);

    // mthi/mtlo then divide by zero
    run_op(4'd5, 32'h1234_5678, 32'd0, cyc);
    check("mthi_busy_cycles", cyc, 0);
    run_op(4'd6, 32'hCAFE_F00D, 32'd0, cyc);
    check("mtlo_lo", bus.LO, 32'hCAFE_F00D);
    run_op(4'd3, 32'd5, 32'd0, cyc);
    check("divz_busy_cycles", cyc, DC);
    check("divz_hi", bus.HI, 32'h1234_5678);
    check("divz_lo", bus.LO, 32'hCAFE_F00D);

    // start while busy is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.MDUOp = 4'd2; bus.A = 32'd3; bus.B = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.MDUOp = 4'd3; bus.A = 32'd9; bus.B = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 2;
    while (bus.busy && cyc < 50) begin cyc++; @(negedge clk); end
    $display("multu_overlap busy_cycles=%0d HI=%08h LO=%08h", cyc, bus.HI, bus.LO);
    check("overlap_busy_cycles", cyc, MC);
    check("overlap_lo", bus.LO, 32'd12);
    check("overlap_hi", bus.HI, 32'd0);

    // reset aborts an in-flight op
    @(negedge clk);
    bus.start = 1'b1; bus.MDUOp = 4'd2; bus.A = 32'hFFFF_FFFF; bus.B = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_hi", bus.HI, 32'd0);
    check("abort_lo", bus.LO, 32'd0);
    repeat (MC + 2) @(negedge clk);
    check("abort_no_late_hi", bus.HI, 32'd0);
    check("abort_no_late_lo", bus.LO, 32'd0);
    $display("reset_abort HI=%08h LO=%08h busy=%0b", bus.HI, bus.LO, bus.busy);

    // maddu (or no-op when the feature is absent)
    run_op(4'd5, 32'd0, 32'd0, cyc);
    run_op(4'd6, 32'hFFFF_FFFF, 32'd0, cyc);
    run_op(4'd8, 32'd1, 32'd1, cyc);
`ifdef MDU_MADD_EN
    check("maddu_busy_cycles", cyc, MC);
    check("maddu_hi", bus.HI, 32'd1);
    check("maddu_lo", bus.LO, 32'd0);
`else
    check("maddu_off_busy_cycles", cyc, 0);
    check("maddu_off_hi", bus.HI, 32'd0);
    check("maddu_off_lo", bus.LO, 32'hFFFF_FFFF);
`endif

    // randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 399) == 0);
      bus.start = ($urandom_range(0, 2) == 0);
      bus.MDUOp = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(1, 8));
      bus.A     = pick();
      bus.B     = pick();
      if (bus.start)
        $display("rand start op=%0d a=%08h b=%08h rst=%0b busy=%0b", bus.MDUOp, bus.A, bus.B, rst, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    repeat (DC + 2) @(negedge clk);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
